pep_batch_cmd_builder: RTL and testbench

- Producer side of the PBS batch capacity contract: accepts a stream of PBS requests and allocates each a PBS slot id (pid) from a TOTAL_PBS_NB pool.
- Assigns each request a GRAM id and groups requests into batches of at most BATCH_PBS_NB.
- Issues one batch command per closed batch to the pe_pbs processing pipe.
- Frees slots in order on completion notifications from the pipe, so the pipe is never handed more PBS than it can store.

---
 rtl/pep_batch_cmd_builder.sv | 128 ++++++++++++
 tb/tb_pep_batch_cmd_builder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pep_batch_cmd_builder.sv
// PBS batch command builder: allocates pids from a fixed pool, groups them into
// batches, issues one command per closed batch and frees pids in order on completion.
module pep_batch_cmd_builder #(
    parameter int BATCH_PBS_NB = 9,
    parameter int TOTAL_PBS_NB = 18,
    parameter int GRAM_NB      = 3,
    parameter int TIMEOUT_CYC  = 64,
    parameter int PID_W        = $clog2(TOTAL_PBS_NB),
    parameter int BNB_W        = $clog2(BATCH_PBS_NB + 1),
    parameter int GID_W        = (GRAM_NB > 1) ? $clog2(GRAM_NB) : 1,
    parameter int INF_W        = $clog2(TOTAL_PBS_NB + 1)
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             in_pbs_vld,
    output logic             in_pbs_rdy,
    input  logic             flush,
    output logic             out_pbs_vld,
    input  logic             out_pbs_rdy,
    output logic [PID_W-1:0] out_pbs_pid,
    output logic [GID_W-1:0] out_pbs_gid,
    output logic             batch_cmd_vld,
    input  logic             batch_cmd_rdy,
    output logic [BNB_W-1:0] batch_cmd_pbs_nb,
    output logic [PID_W-1:0] batch_cmd_first_pid,
    input  logic             done_vld,
    output logic [INF_W-1:0] inflight_nb,
    output logic             err_underflow
);
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_CMD} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_run;
    logic [PID_W-1:0] r_alloc_ptr, r_free_ptr, r_out_pid, r_first_pid;
    logic [GID_W-1:0] r_alloc_gid, r_out_gid;
    logic [INF_W-1:0] r_inflight;
    logic [BNB_W-1:0] r_cnt, w_cnt_inc;
    logic [TMR_W-1:0] r_timer;
    logic             r_out_vld, r_err;
    logic             w_accept, w_out_free, w_close, w_done_ok, w_cmd_hs, w_alloc_wrap;

    assign w_out_free   = !r_out_vld || out_pbs_rdy;
    // r_run keeps rdy low while reset is held, so all outputs read as idle
    assign in_pbs_rdy   = r_run && (r_state == S_FILL) &&
                          (r_inflight < INF_W'(TOTAL_PBS_NB)) && w_out_free;
    assign w_accept     = in_pbs_vld && in_pbs_rdy;
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_cmd_hs     = (r_state == S_CMD) && batch_cmd_rdy;
    assign w_alloc_wrap = (r_alloc_ptr == PID_W'(TOTAL_PBS_NB - 1));
    // a same-cycle accept makes a done on an empty pool legitimate (net zero)
    assign w_done_ok    = done_vld && ((r_inflight != '0) || w_accept);

    assign w_close = (w_accept && (w_cnt_inc == BNB_W'(BATCH_PBS_NB))) ||
                     (flush && ((r_cnt != '0) || w_accept)) ||
                     (!w_accept && (r_cnt != '0) && (r_timer == TMR_W'(TIMEOUT_CYC - 1)));

    always_ff @(posedge clk) begin
        if (!s_rst_n) r_state <= S_FILL;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_close)       w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_free)    w_state_nxt = S_CMD;
            S_CMD:   if (batch_cmd_rdy) w_state_nxt = S_FILL;
            default:                    w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_run       <= 1'b0;
            r_alloc_ptr <= '0;
            r_alloc_gid <= '0;
            r_free_ptr  <= '0;
            r_inflight  <= '0;
            r_out_vld   <= 1'b0;
            r_out_pid   <= '0;
            r_out_gid   <= '0;
            r_cnt       <= '0;
            r_first_pid <= '0;
            r_timer     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_err <= done_vld && !w_done_ok;
            if (w_accept) begin
                r_alloc_ptr <= w_alloc_wrap ? '0 : r_alloc_ptr + 1'b1;
                // gid tracks pid mod GRAM_NB; restart with the pid wrap
                r_alloc_gid <= (w_alloc_wrap || r_alloc_gid == GID_W'(GRAM_NB - 1))
                               ? '0 : r_alloc_gid + 1'b1;
                r_out_vld   <= 1'b1;
                r_out_pid   <= r_alloc_ptr;
                r_out_gid   <= r_alloc_gid;
            end else if (out_pbs_rdy) begin
                r_out_vld   <= 1'b0;
            end
            if (w_done_ok)
                r_free_ptr <= (r_free_ptr == PID_W'(TOTAL_PBS_NB - 1)) ? '0 : r_free_ptr + 1'b1;
            if (w_accept && !w_done_ok)      r_inflight <= r_inflight + 1'b1;
            else if (!w_accept && w_done_ok) r_inflight <= r_inflight - 1'b1;
            if (w_accept) begin
                r_cnt <= w_cnt_inc;
                if (r_cnt == '0) r_first_pid <= r_alloc_ptr;
            end else if (w_cmd_hs) begin
                r_cnt <= '0;
            end
            if (w_accept || w_cmd_hs)
                r_timer <= '0;
            else if ((r_state == S_FILL) && (r_cnt != '0) &&
                     (r_timer != TMR_W'(TIMEOUT_CYC - 1)))
                r_timer <= r_timer + 1'b1;
        end
    end

    assign out_pbs_vld         = r_out_vld;
    assign out_pbs_pid         = r_out_pid;
    assign out_pbs_gid         = r_out_gid;
    assign batch_cmd_vld       = (r_state == S_CMD);
    assign batch_cmd_pbs_nb    = r_cnt;
    assign batch_cmd_first_pid = r_first_pid;
    assign inflight_nb         = r_inflight;
    assign err_underflow       = r_err;
endmodule

// File: tb/tb_pep_batch_cmd_builder.sv
// Directed bench for pep_batch_cmd_builder: records handshakes and checks them
// against hand-computed pid/gid/batch sequences.
module tb_pep_batch_cmd_builder;
    logic       clk = 1'b0;
    logic       s_rst_n, in_pbs_vld, in_pbs_rdy, flush;
    logic       out_pbs_vld, out_pbs_rdy, batch_cmd_vld, batch_cmd_rdy;
    logic [4:0] out_pbs_pid, batch_cmd_first_pid, inflight_nb;
    logic [1:0] out_pbs_gid;
    logic [3:0] batch_cmd_pbs_nb;
    logic       done_vld, err_underflow;

    int total = 0;
    int bad   = 0;
    int out_pid_q[$], out_gid_q[$], bat_nb_q[$], bat_first_q[$], bat_at_q[$];
    int out_hs = 0;

    always #5 clk = ~clk;

    pep_batch_cmd_builder dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .in_pbs_vld(in_pbs_vld), .in_pbs_rdy(in_pbs_rdy), .flush(flush),
        .out_pbs_vld(out_pbs_vld), .out_pbs_rdy(out_pbs_rdy),
        .out_pbs_pid(out_pbs_pid), .out_pbs_gid(out_pbs_gid),
        .batch_cmd_vld(batch_cmd_vld), .batch_cmd_rdy(batch_cmd_rdy),
        .batch_cmd_pbs_nb(batch_cmd_pbs_nb), .batch_cmd_first_pid(batch_cmd_first_pid),
        .done_vld(done_vld), .inflight_nb(inflight_nb), .err_underflow(err_underflow)
    );

    // batch recorded before the out handshake of the same edge, so bat_at shows
    // how many PBS had already left when the command was taken
    always @(posedge clk) begin
        if (s_rst_n) begin
            if (batch_cmd_vld && batch_cmd_rdy) begin
                bat_nb_q.push_back(int'(batch_cmd_pbs_nb));
                bat_first_q.push_back(int'(batch_cmd_first_pid));
                bat_at_q.push_back(out_hs);
            end
            if (out_pbs_vld && out_pbs_rdy) begin
                out_pid_q.push_back(int'(out_pbs_pid));
                out_gid_q.push_back(int'(out_pbs_gid));
                out_hs = out_hs + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        s_rst_n = 1'b0; in_pbs_vld = 1'b0; flush = 1'b0; done_vld = 1'b0;
        out_pbs_rdy = 1'b1; batch_cmd_rdy = 1'b1;
        tick(2);
        out_pid_q.delete(); out_gid_q.delete();
        bat_nb_q.delete(); bat_first_q.delete(); bat_at_q.delete();
        out_hs = 0;
    endtask

    task automatic release_rst();
        s_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic send(input int n, output int cycles);
        int got = 0;
        cycles = 0;
        in_pbs_vld = 1'b1;
        while (got < n && cycles < 300) begin
            #1;
            if (in_pbs_rdy) got++;
            @(posedge clk); #1;
            cycles++;
        end
        in_pbs_vld = 1'b0;
        total++;
        if (got != n) begin bad++; $display("FAIL send: accepted %0d required %0d", got, n); end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_pbs_vld, batch_cmd_vld, in_pbs_rdy, err_underflow} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b required 0000",
                            {out_pbs_vld, batch_cmd_vld, in_pbs_rdy, err_underflow});
        end
        total++;
        if (out_pbs_pid !== 5'd0 || out_pbs_gid !== 2'd0 || batch_cmd_pbs_nb !== 4'd0 ||
            batch_cmd_first_pid !== 5'd0 || inflight_nb !== 5'd0) begin
            bad++; $display("FAIL reset_values: pid=%0d gid=%0d nb=%0d first=%0d infl=%0d required all 0",
                            out_pbs_pid, out_pbs_gid, batch_cmd_pbs_nb, batch_cmd_first_pid, inflight_nb);
        end
        release_rst();
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset(); release_rst();
        send(9, cyc);
        total++;
        if (cyc != 9) begin bad++; $display("FAIL b2b_cycles: got %0d required 9", cyc); end
        tick(5);
        total++;
        if (out_pid_q.size() != 9) begin bad++; $display("FAIL b2b_out_count: got %0d required 9", out_pid_q.size()); end
        for (int i = 0; i < out_pid_q.size() && i < 9; i++) begin
            total++;
            if (out_pid_q[i] != i || out_gid_q[i] != i % 3) begin
                bad++; $display("FAIL b2b_pid[%0d]: got pid=%0d gid=%0d required pid=%0d gid=%0d",
                                i, out_pid_q[i], out_gid_q[i], i, i % 3);
            end
        end
        total++;
        if (bat_nb_q.size() != 1 || bat_nb_q[0] != 9 || bat_first_q[0] != 0 || bat_at_q[0] != 9) begin
            bad++; $display("FAIL b2b_batch: got n=%0d nb=%0d first=%0d at=%0d required n=1 nb=9 first=0 at=9",
                            bat_nb_q.size(), bat_nb_q.size() ? bat_nb_q[0] : -1,
                            bat_first_q.size() ? bat_first_q[0] : -1, bat_at_q.size() ? bat_at_q[0] : -1);
        end
        total++;
        if (inflight_nb !== 5'd9) begin bad++; $display("FAIL b2b_inflight: got %0d required 9", inflight_nb); end
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset(); release_rst();
        send(4, cyc);
        tick(60);
        total++;
        if (bat_nb_q.size() != 0) begin bad++; $display("FAIL tmo_early: got %0d batches required 0", bat_nb_q.size()); end
        tick(10);
        total++;
        if (bat_nb_q.size() != 1 || bat_nb_q[0] != 4 || bat_first_q[0] != 0) begin
            bad++; $display("FAIL tmo_batch1: got n=%0d nb=%0d first=%0d required n=1 nb=4 first=0",
                            bat_nb_q.size(), bat_nb_q.size() ? bat_nb_q[0] : -1, bat_first_q.size() ? bat_first_q[0] : -1);
        end
        send(2, cyc);
        tick(70);
        total++;
        if (out_pid_q.size() != 6 || out_pid_q[4] != 4 || out_pid_q[5] != 5) begin
            bad++; $display("FAIL tmo_pids: got n=%0d required n=6 with pids 4,5", out_pid_q.size());
        end
        total++;
        if (bat_nb_q.size() != 2 || bat_nb_q[1] != 2 || bat_first_q[1] != 4) begin
            bad++; $display("FAIL tmo_batch2: got n=%0d nb=%0d first=%0d required n=2 nb=2 first=4",
                            bat_nb_q.size(), bat_nb_q.size() > 1 ? bat_nb_q[1] : -1,
                            bat_first_q.size() > 1 ? bat_first_q[1] : -1);
        end
    endtask

    task automatic test_pool_full();
        int cyc;
        do_reset(); release_rst();
        send(18, cyc);
        tick(5);
        total++;
        if (bat_nb_q.size() != 2 || bat_nb_q[0] != 9 || bat_first_q[0] != 0 ||
            bat_nb_q[1] != 9 || bat_first_q[1] != 9 || bat_at_q[1] != 18) begin
            bad++; $display("FAIL full_batches: got n=%0d required two batches (9,0) (9,9)", bat_nb_q.size());
        end
        for (int i = 0; i < 18 && i < out_pid_q.size(); i++) begin
            total++;
            if (out_pid_q[i] != i) begin bad++; $display("FAIL full_pid[%0d]: got %0d required %0d", i, out_pid_q[i], i); end
        end
        total++;
        if (inflight_nb !== 5'd18 || in_pbs_rdy !== 1'b0) begin
            bad++; $display("FAIL full_stall: got infl=%0d rdy=%b required infl=18 rdy=0", inflight_nb, in_pbs_rdy);
        end
        done_vld = 1'b1; tick(); done_vld = 1'b0;
        total++;
        if (inflight_nb !== 5'd17) begin bad++; $display("FAIL full_done: got %0d required 17", inflight_nb); end
        send(1, cyc);
        tick(2);
        total++;
        if (out_pid_q.size() != 19 || out_pid_q[18] != 0 || out_gid_q[18] != 0) begin
            bad++; $display("FAIL full_wrap: got n=%0d pid=%0d gid=%0d required n=19 pid=0 gid=0", out_pid_q.size(),
                            out_pid_q.size() > 18 ? out_pid_q[18] : -1, out_gid_q.size() > 18 ? out_gid_q[18] : -1);
        end
        total++;
        if (inflight_nb !== 5'd18) begin bad++; $display("FAIL full_refill: got %0d required 18", inflight_nb); end
    endtask

    task automatic test_flush_drain();
        int cyc;
        do_reset(); release_rst();
        send(3, cyc);
        out_pbs_rdy = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (batch_cmd_vld !== 1'b0 || out_pbs_vld !== 1'b1 || out_pbs_pid !== 5'd2 || in_pbs_rdy !== 1'b0) begin
                bad++; $display("FAIL drain_hold[%0d]: got bvld=%b ovld=%b pid=%0d rdy=%b required 0 1 2 0",
                                i, batch_cmd_vld, out_pbs_vld, out_pbs_pid, in_pbs_rdy);
            end
            tick();
        end
        out_pbs_rdy = 1'b1;
        tick();
        total++;
        if (batch_cmd_vld !== 1'b1 || batch_cmd_pbs_nb !== 4'd3 || batch_cmd_first_pid !== 5'd0) begin
            bad++; $display("FAIL drain_cmd: got vld=%b nb=%0d first=%0d required 1 3 0",
                            batch_cmd_vld, batch_cmd_pbs_nb, batch_cmd_first_pid);
        end
        tick();
        total++;
        if (bat_nb_q.size() != 1 || bat_at_q[0] != 3) begin
            bad++; $display("FAIL drain_order: got n=%0d at=%0d required n=1 at=3",
                            bat_nb_q.size(), bat_at_q.size() ? bat_at_q[0] : -1);
        end
        flush = 1'b1; tick(10); flush = 1'b0;
        total++;
        if (bat_nb_q.size() != 1 || batch_cmd_vld !== 1'b0) begin
            bad++; $display("FAIL flush_empty: got n=%0d vld=%b required n=1 vld=0", bat_nb_q.size(), batch_cmd_vld);
        end
    endtask

    task automatic test_underflow();
        int cyc;
        do_reset(); release_rst();
        done_vld = 1'b1; tick(); done_vld = 1'b0;
        total++;
        if (err_underflow !== 1'b1 || inflight_nb !== 5'd0) begin
            bad++; $display("FAIL uflow_pulse: got err=%b infl=%0d required 1 0", err_underflow, inflight_nb);
        end
        tick();
        total++;
        if (err_underflow !== 1'b0) begin bad++; $display("FAIL uflow_clear: got %b required 0", err_underflow); end
        send(5, cyc);
        tick();
        in_pbs_vld = 1'b1; done_vld = 1'b1;
        #1;
        total++;
        if (in_pbs_rdy !== 1'b1) begin bad++; $display("FAIL both_rdy: got %b required 1", in_pbs_rdy); end
        tick(); in_pbs_vld = 1'b0; done_vld = 1'b0;
        total++;
        if (inflight_nb !== 5'd5 || err_underflow !== 1'b0) begin
            bad++; $display("FAIL both_net: got infl=%0d err=%b required 5 0", inflight_nb, err_underflow);
        end
    endtask

    task automatic test_reset_in_cmd();
        int cyc, base;
        do_reset();
        batch_cmd_rdy = 1'b0;
        release_rst();
        send(9, cyc);
        tick(3);
        total++;
        if (batch_cmd_vld !== 1'b1 || batch_cmd_pbs_nb !== 4'd9) begin
            bad++; $display("FAIL cmd_wait: got vld=%b nb=%0d required 1 9", batch_cmd_vld, batch_cmd_pbs_nb);
        end
        s_rst_n = 1'b0; tick();
        total++;
        if ({out_pbs_vld, batch_cmd_vld, in_pbs_rdy, err_underflow} !== 4'b0 || inflight_nb !== 5'd0 ||
            batch_cmd_pbs_nb !== 4'd0 || batch_cmd_first_pid !== 5'd0 || out_pbs_pid !== 5'd0) begin
            bad++; $display("FAIL rst_mid: got flags=%b infl=%0d nb=%0d first=%0d pid=%0d required all 0",
                            {out_pbs_vld, batch_cmd_vld, in_pbs_rdy, err_underflow}, inflight_nb,
                            batch_cmd_pbs_nb, batch_cmd_first_pid, out_pbs_pid);
        end
        base = out_pid_q.size();
        batch_cmd_rdy = 1'b1;
        release_rst();
        send(1, cyc);
        tick(2);
        total++;
        if (out_pid_q.size() != base + 1 || out_pid_q[base] != 0 || bat_nb_q.size() != 0) begin
            bad++; $display("FAIL rst_restart: got n=%0d pid=%0d batches=%0d required n=%0d pid=0 batches=0",
                            out_pid_q.size(), out_pid_q.size() > base ? out_pid_q[base] : -1,
                            bat_nb_q.size(), base + 1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_timeout();
        test_pool_full();
        test_flush_drain();
        test_underflow();
        test_reset_in_cmd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
